// File: rtl/sgm_pp_pkg.sv
// Shared types and constants for the SGM post-processing pixel path.
package sgm_pp_pkg;

  // Default geometry: 8.8 unsigned disparity, 11-bit column space
  localparam int unsigned PP_WIDTH  = 16;
  localparam int unsigned PP_AWIDTH = 11;
  localparam int unsigned PP_DEPTH  = 2048;

  // Per-pixel validity flags as produced by the LR-consistency check
  localparam logic [1:0] FLAG_OK   = 2'b00;
  localparam logic [1:0] FLAG_MISM = 2'b01;
  localparam logic [1:0] FLAG_OCCL = 2'b10;

  // Hole-filler sequencing
  typedef enum logic [1:0] {
    PASS,
    HOLD,
    FLUSH,
    EMIT
  } state_e;

  // Collapse the raw {occl,mism} pair onto one of the three encodings;
  // a pixel flagged both ways is handled as an occlusion.
  function automatic logic [1:0] norm_flag(input logic [1:0] raw);
    if (raw[1]) begin
      return FLAG_OCCL;
    end
    if (raw[0]) begin
      return FLAG_MISM;
    end
    return FLAG_OK;
  endfunction

endpackage

// File: rtl/hole_run_buffer.sv
// Flag store for one run of holes. Writes and reads both restart at entry 0
// for every run; the read port is registered, so the consumer must issue the
// read one cycle before it needs the flag.
module hole_run_buffer
  import sgm_pp_pkg::*;
#(
  parameter int unsigned AWIDTH = PP_AWIDTH,
  parameter int unsigned DEPTH  = PP_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic              i_wr_first,
  input  logic [1:0]        i_wr_flag,
  input  logic              i_rd_en,
  input  logic              i_rd_first,
  output logic [1:0]        o_rd_flag,
  output logic [AWIDTH-1:0] o_rd_cnt
);

  logic [1:0]        r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [1:0]        r_rd_flag;

  logic [AWIDTH-1:0] w_wr_addr;
  logic [AWIDTH-1:0] w_rd_addr;
  logic              w_bypass;

  // Address selection; a same-address write and read returns the new flag
  always_comb begin
    w_wr_addr = i_wr_first ? '0 : r_wr_ptr;
    w_rd_addr = i_rd_first ? '0 : r_rd_ptr;
    w_bypass  = i_wr_en && i_rd_en && (w_wr_addr == w_rd_addr);
  end

  // Storage array, intentionally left uninitialised
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[w_wr_addr] <= i_wr_flag;
    end
  end

  // Pointers and registered read data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_flag <= FLAG_OK;
    end else begin
      if (i_wr_en) begin
        r_wr_ptr <= w_wr_addr + AWIDTH'(1);
      end
      if (i_rd_en) begin
        r_rd_ptr  <= w_rd_addr + AWIDTH'(1);
        r_rd_flag <= w_bypass ? i_wr_flag : r_mem[w_rd_addr];
      end
    end
  end

  assign o_rd_flag = r_rd_flag;
  // Number of entries fetched so far in this run
  assign o_rd_cnt  = r_rd_ptr;

endmodule

// File: rtl/lr_hole_filler.sv
// Replaces occluded/mismatched disparities with values taken from the nearest
// valid pixels on the same row. Valid pixels stream through with one cycle of
// latency; a run of holes is parked until its right neighbour or the row end
// arrives, then replayed in order, so the output order matches the input.
module lr_hole_filler
  import sgm_pp_pkg::*;
#(
  parameter int unsigned WIDTH  = PP_WIDTH,
  parameter int unsigned AWIDTH = PP_AWIDTH,
  parameter int unsigned DEPTH  = PP_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [AWIDTH-1:0] img_width,
  input  logic [WIDTH+1:0]  data_in,
  input  logic              valid_in,
  output logic              in_ready,
  output logic [WIDTH-1:0]  data_out,
  output logic              filled,
  output logic              valid_out
);

  state_e            r_state, w_state_nxt;
  logic [AWIDTH-1:0] r_col, w_col_nxt;
  logic [AWIDTH-1:0] r_run_len, w_run_len_nxt;
  logic [WIDTH-1:0]  r_left, w_left_nxt;
  logic [WIDTH-1:0]  r_right, w_right_nxt;
  logic              r_have_left, w_have_left_nxt;
  logic              r_have_right, w_have_right_nxt;
  logic              r_right_last, w_right_last_nxt;
  logic [WIDTH-1:0]  r_data_out, w_data_out_nxt;
  logic              r_filled, w_filled_nxt;
  logic              r_valid_out, w_valid_out_nxt;

  logic [1:0]        w_in_flag;
  logic [WIDTH-1:0]  w_in_disp;
  logic              w_hole;
  logic              w_last_col;
  logic              w_accept;
  logic              w_flush_last;
  logic [WIDTH-1:0]  w_fill;

  logic              w_wr_en;
  logic              w_wr_first;
  logic              w_rd_en;
  logic              w_rd_first;
  logic [1:0]        w_buf_flag;
  logic [AWIDTH-1:0] w_rd_cnt;

  // Fill rule: occlusions take the background (smaller disparity), mismatches
  // the floored midpoint; a single neighbour is copied, none yields zero.
  function automatic logic [WIDTH-1:0] fill_value(
    input logic [1:0]       flag,
    input logic             have_l,
    input logic             have_r,
    input logic [WIDTH-1:0] left,
    input logic [WIDTH-1:0] right
  );
    logic [WIDTH:0] sum;
    sum = {1'b0, left} + {1'b0, right};
    if (have_l && have_r) begin
      if (flag == FLAG_MISM) begin
        return sum[WIDTH:1];
      end
      return (left < right) ? left : right;
    end
    if (have_l) begin
      return left;
    end
    if (have_r) begin
      return right;
    end
    return '0;
  endfunction

  hole_run_buffer #(
    .AWIDTH (AWIDTH),
    .DEPTH  (DEPTH)
  ) u_run_buf (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_wr_en    (w_wr_en),
    .i_wr_first (w_wr_first),
    .i_wr_flag  (w_in_flag),
    .i_rd_en    (w_rd_en),
    .i_rd_first (w_rd_first),
    .o_rd_flag  (w_buf_flag),
    .o_rd_cnt   (w_rd_cnt)
  );

  assign in_ready = (r_state == PASS) || (r_state == HOLD);

  // Input decode, handshake and fill value for the entry being replayed
  always_comb begin
    w_in_flag    = norm_flag(data_in[WIDTH+1:WIDTH]);
    w_in_disp    = data_in[WIDTH-1:0];
    w_hole       = (w_in_flag != FLAG_OK);
    w_accept     = clken && valid_in && in_ready;
    w_last_col   = (r_col == (img_width - AWIDTH'(1)));
    w_flush_last = (w_rd_cnt == r_run_len);
    w_fill       = fill_value(w_buf_flag, r_have_left, r_have_right, r_left, r_right);
  end

  // Next-state, column tracking and buffer control; everything holds while clken is low
  always_comb begin
    w_state_nxt      = r_state;
    w_col_nxt        = r_col;
    w_run_len_nxt    = r_run_len;
    w_left_nxt       = r_left;
    w_right_nxt      = r_right;
    w_have_left_nxt  = r_have_left;
    w_have_right_nxt = r_have_right;
    w_right_last_nxt = r_right_last;
    w_data_out_nxt   = r_data_out;
    w_filled_nxt     = r_filled;
    w_valid_out_nxt  = r_valid_out;
    w_wr_en          = 1'b0;
    w_wr_first       = 1'b0;
    w_rd_en          = 1'b0;
    w_rd_first       = 1'b0;

    if (w_accept) begin
      w_col_nxt = w_last_col ? '0 : r_col + AWIDTH'(1);
    end

    if (clken) begin
      w_valid_out_nxt = 1'b0;
      unique case (r_state)
        PASS: begin
          if (w_accept) begin
            if (!w_hole) begin
              w_data_out_nxt  = w_in_disp;
              w_filled_nxt    = 1'b0;
              w_valid_out_nxt = 1'b1;
              w_left_nxt      = w_in_disp;
              // A row-final pixel is never a left neighbour for the next row
              w_have_left_nxt = !w_last_col;
            end else begin
              w_wr_en       = 1'b1;
              w_wr_first    = 1'b1;
              w_run_len_nxt = AWIDTH'(1);
              if (w_last_col) begin
                // Prefetch entry 0 now so FLUSH has a flag on its first cycle
                w_rd_en          = 1'b1;
                w_rd_first       = 1'b1;
                w_have_right_nxt = 1'b0;
                w_state_nxt      = FLUSH;
              end else begin
                w_state_nxt = HOLD;
              end
            end
          end
        end

        HOLD: begin
          if (w_accept) begin
            if (w_hole) begin
              w_wr_en       = 1'b1;
              w_run_len_nxt = r_run_len + AWIDTH'(1);
              if (w_last_col) begin
                w_rd_en          = 1'b1;
                w_rd_first       = 1'b1;
                w_have_right_nxt = 1'b0;
                w_state_nxt      = FLUSH;
              end
            end else begin
              w_right_nxt      = w_in_disp;
              w_have_right_nxt = 1'b1;
              w_right_last_nxt = w_last_col;
              w_rd_en          = 1'b1;
              w_rd_first       = 1'b1;
              w_state_nxt      = FLUSH;
            end
          end
        end

        FLUSH: begin
          w_data_out_nxt  = w_fill;
          w_filled_nxt    = 1'b1;
          w_valid_out_nxt = 1'b1;
          if (w_flush_last) begin
            if (r_have_right) begin
              w_state_nxt = EMIT;
            end else begin
              // Run reached the row end: nothing carries into the next row
              w_have_left_nxt = 1'b0;
              w_run_len_nxt   = '0;
              w_state_nxt     = PASS;
            end
          end else begin
            w_rd_en = 1'b1;
          end
        end

        EMIT: begin
          w_data_out_nxt   = r_right;
          w_filled_nxt     = 1'b0;
          w_valid_out_nxt  = 1'b1;
          w_left_nxt       = r_right;
          w_have_left_nxt  = !r_right_last;
          w_have_right_nxt = 1'b0;
          w_run_len_nxt    = '0;
          w_state_nxt      = PASS;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= PASS;
      r_col        <= '0;
      r_run_len    <= '0;
      r_left       <= '0;
      r_right      <= '0;
      r_have_left  <= 1'b0;
      r_have_right <= 1'b0;
      r_right_last <= 1'b0;
      r_data_out   <= '0;
      r_filled     <= 1'b0;
      r_valid_out  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_col        <= w_col_nxt;
      r_run_len    <= w_run_len_nxt;
      r_left       <= w_left_nxt;
      r_right      <= w_right_nxt;
      r_have_left  <= w_have_left_nxt;
      r_have_right <= w_have_right_nxt;
      r_right_last <= w_right_last_nxt;
      r_data_out   <= w_data_out_nxt;
      r_filled     <= w_filled_nxt;
      r_valid_out  <= w_valid_out_nxt;
    end
  end

  assign data_out  = r_data_out;
  assign filled    = r_filled;
  assign valid_out = r_valid_out;

endmodule
